// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: opcodes, bubble word,
// fetch-stage state encoding and PC width.
package mips_pkg;

  localparam int PC_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } if_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry skid buffer that parks a fetched word while stage_id is stalled.
module if_skid_reg (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      dout  <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (unload) begin
      dout  <= 32'h0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, feeds stage_id.
// Build option IF_HALT_DETECT_EN stops fetching after an OP_HALT instruction.
module stage_if
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        isJumped,
  input  logic [31:0] jumpTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [31:0] pc_id,
  output logic        nop_if,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  // Handshake: a fetch completes on a rising edge where imem_req=1 and
  // imem_ack=1; imem_addr is held stable until then. ack with req=0 is ignored.

  if_state_t       state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] target;
  logic            skid_load;
  logic            skid_unload;
  logic [31:0]     skid_data;
  logic            skid_valid;
  logic            halt_fetch;
  logic            halt_skid;

  assign pc_next   = pc + STEP;
  assign target    = jumpTarget & ~32'h3;
  assign state_dbg = state;

  assign skid_load   = !isJumped && (state == ST_FETCH) && imem_req && imem_ack && stall;
  assign skid_unload = !isJumped && (state == ST_HOLD) && !stall;

`ifdef IF_HALT_DETECT_EN
  assign halt_fetch = is_halt(imem_rdata);
  assign halt_skid  = is_halt(skid_data);
  assign halted     = (state == ST_HALTED);
`else
  assign halt_fetch = 1'b0;
  assign halt_skid  = 1'b0;
  assign halted     = 1'b0;
`endif

  if_skid_reg u_skid (
    .clock  (clock),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (isJumped),
    .din    (imem_rdata),
    .dout   (skid_data),
    .valid  (skid_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      instr     <= NOP_WORD;
      pc_id     <= '0;
      nop_if    <= 1'b1;
    end else if (isJumped) begin
      pc       <= target;
      instr    <= NOP_WORD;
      pc_id    <= '0;
      nop_if   <= 1'b1;
      imem_req <= 1'b1;
      // An unanswered request must be drained at its old address first.
      if (imem_req && !imem_ack) begin
        state <= ST_FLUSH;
      end else begin
        state     <= ST_FETCH;
        imem_addr <= target;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          imem_req <= 1'b1;
          if (imem_req && imem_ack) begin
            pc        <= pc_next;
            imem_addr <= pc_next;
            if (stall) begin
              state    <= ST_HOLD;
              imem_req <= 1'b0;
            end else begin
              instr  <= imem_rdata;
              pc_id  <= pc_next;
              nop_if <= 1'b0;
              if (halt_fetch) begin
                state    <= ST_HALTED;
                imem_req <= 1'b0;
              end
            end
          end else if (!stall) begin
            instr  <= NOP_WORD;
            nop_if <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            // pc already advanced past the parked word, so it is that word's PC+4.
            instr  <= skid_valid ? skid_data : NOP_WORD;
            pc_id  <= pc;
            nop_if <= !skid_valid;
            if (skid_valid && halt_skid) begin
              state <= ST_HALTED;
            end else begin
              state    <= ST_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          instr    <= NOP_WORD;
          nop_if   <= 1'b1;
          imem_req <= 1'b1;
          if (imem_ack) begin
            state     <= ST_FETCH;
            imem_addr <= pc;
          end
        end
`ifdef IF_HALT_DETECT_EN
        ST_HALTED: begin
          instr    <= NOP_WORD;
          nop_if   <= 1'b1;
          imem_req <= 1'b0;
        end
`endif
        default: begin
          state    <= ST_FETCH;
          imem_req <= 1'b0;
          instr    <= NOP_WORD;
          nop_if   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if with a scoreboard of expected {instr, pc_id}.
// Halt checks are included when IF_HALT_DETECT_EN is defined.
module tb_stage_if;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        isJumped = 1'b0;
  logic [31:0] jumpTarget = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_id;
  logic        nop_if;
  logic        halted;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic flushing = 1'b0;

  stage_if dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .isJumped   (isJumped),
    .jumpTarget (jumpTarget),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .pc_id      (pc_id),
    .nop_if     (nop_if),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_000c: return 32'hac22_0000;
      32'h0000_0080: return 32'hfc00_0000;
      default:       return {6'h08, a[25:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then score any new word.
  task automatic step(input logic s, input logic j, input logic [31:0] t, input logic a);
    logic ack_now;
    logic [63:0] e;
    ack_now    = a & imem_req;
    stall      = s;
    isJumped   = j;
    jumpTarget = t;
    imem_ack   = ack_now;
    imem_rdata = ack_now ? mem_word(imem_addr) : 32'hdead_beef;
    if (ack_now && !j && !flushing) exp_q.push_back({mem_word(imem_addr), imem_addr + 32'd4});
    if (j) flushing = imem_req && !ack_now;
    else if (ack_now) flushing = 1'b0;
    @(posedge clock);
    #1;
    stall    = 1'b0;
    isJumped = 1'b0;
    imem_ack = 1'b0;
    if (!s && !j && nop_if === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {31'h0, nop_if}, 32'h1);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", instr, e[63:32]);
        check("sb_pc_id", pc_id, e[31:0]);
      end
    end
  endtask

  initial begin
    // Reset state
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_nop", {31'h0, nop_if}, 32'h1);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    reset = 1'b1;
    step(0, 0, 32'h0, 0);
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);

    // Zero-wait fetches
    step(0, 0, 32'h0, 1);
    check("zw_addr4", imem_addr, 32'h4);
    check("zw_nop", {31'h0, nop_if}, 32'h0);
    step(0, 0, 32'h0, 1);
    check("zw_addr8", imem_addr, 32'h8);

    // Two-cycle latency at address 8
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 32'h0, 0);
      check("lat_nop", {31'h0, nop_if}, 32'h1);
      check("lat_instr", instr, 32'h0);
      check("lat_addr", imem_addr, 32'h8);
    end
    step(0, 0, 32'h0, 1);
    check("lat_addr12", imem_addr, 32'hc);

    // Stall on the ack edge: word parked, outputs frozen for 3 cycles
    step(1, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      check("stall_instr", instr, 32'h2000_0008);
      check("stall_pc_id", pc_id, 32'hc);
      check("stall_nop", {31'h0, nop_if}, 32'h0);
      if (i < 2) step(1, 0, 32'h0, 0);
    end
    step(0, 0, 32'h0, 0);
    check("unstall_req", {31'h0, imem_req}, 32'h1);
    check("unstall_addr", imem_addr, 32'h10);
    check("unstall_q_empty", exp_q.size(), 32'h0);

    // Jump while request to 0x10 is outstanding
    step(0, 1, 32'h40, 0);
    check("jmp_nop", {31'h0, nop_if}, 32'h1);
    check("jmp_instr", instr, 32'h0);
    check("jmp_pc_id", pc_id, 32'h0);
    check("jmp_old_addr", imem_addr, 32'h10);
    check("jmp_req", {31'h0, imem_req}, 32'h1);
    step(0, 0, 32'h0, 0);
    check("flush_addr", imem_addr, 32'h10);
    step(0, 0, 32'h0, 1);
    check("flush_discard_nop", {31'h0, nop_if}, 32'h1);
    check("flush_new_addr", imem_addr, 32'h40);
    step(0, 0, 32'h0, 1);
    check("jmp_next_addr", imem_addr, 32'h44);

    // Jump with stall: jump wins; low target bits ignored
    step(1, 1, 32'h103, 0);
    check("jmpstall_nop", {31'h0, nop_if}, 32'h1);
    step(0, 0, 32'h0, 1);
    check("jmpstall_addr", imem_addr, 32'h100);
    check("jmpstall_req", {31'h0, imem_req}, 32'h1);

    // Jump coinciding with ack, then PC wrap
    step(0, 1, 32'hffff_fffc, 1);
    check("wrap_addr", imem_addr, 32'hffff_fffc);
    step(0, 0, 32'h0, 1);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Halt opcode at 0x80
    step(0, 1, 32'h80, 1);
    step(0, 0, 32'h0, 1);
`ifdef IF_HALT_DETECT_EN
    check("halt_req", {31'h0, imem_req}, 32'h0);
    check("halt_flag", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 1);
      check("halted_flag", {31'h0, halted}, 32'h1);
      check("halted_req", {31'h0, imem_req}, 32'h0);
      check("halted_nop", {31'h0, nop_if}, 32'h1);
    end
    step(0, 1, 32'h20, 0);
    check("resume_halted", {31'h0, halted}, 32'h0);
    check("resume_req", {31'h0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h20);
    step(0, 0, 32'h0, 1);
`else
    check("nohalt_flag", {31'h0, halted}, 32'h0);
    check("nohalt_req", {31'h0, imem_req}, 32'h1);
    check("nohalt_addr", imem_addr, 32'h84);
    step(0, 0, 32'h0, 1);
`endif

    // Reset asserted with a request outstanding
    reset = 1'b0;
    @(posedge clock); #1;
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    check("midrst_nop", {31'h0, nop_if}, 32'h1);
    check("midrst_instr", instr, 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    reset = 1'b1;
    flushing = 1'b0;
    step(0, 0, 32'h0, 0);
    check("postrst_req", {31'h0, imem_req}, 32'h1);
    check("postrst_addr", imem_addr, 32'h0);
    step(0, 0, 32'h0, 1);
    check("final_q_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
